// File: rtl/painterengine_gpu_dma_reader_if.sv
// AXI4 read-address and read-data channels between the GPU DMA reader (master) and memory (slave).
// Pure wiring; the master drives AR* and RREADY, the slave drives ARREADY and R*.
interface painterengine_gpu_dma_reader_if;
    logic        arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic [3:0]  arqos;
    logic        arvalid;
    logic        arready;
    logic        rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/painterengine_gpu_dma_reader.sv
// One-shot AXI4 read DMA streaming words to a one-hot selected channel; first ARVALID 3 cycles after reset,
// R data passes through with zero latency and consumer backpressure drives RREADY directly. Watchdog: PAINTERENGINE_GPU_READER_TIMEOUT_EN.
module painterengine_gpu_dma_reader #(
    parameter int PARAM_DATA_ALIGN = 32
) (
    input  logic                        i_wire_clock,
    input  logic                        i_wire_resetn,
    input  logic [3:0]                  i_wire_router,
    input  logic [127:0]                i_wire_address,
    input  logic [127:0]                i_wire_length,
    output logic [PARAM_DATA_ALIGN-1:0] o_wire_data,
    output logic [3:0]                  o_wire_data_valid,
    input  logic [3:0]                  i_wire_data_next,
    output logic                        o_wire_done,
    output logic                        o_wire_error,
    output logic [2:0]                  o_wire_error_type,
    painterengine_gpu_dma_reader_if.master m_axi
);

    typedef enum logic [2:0] {
        ROUTING      = 3'd0,
        PARAM_CHECK  = 3'd1,
        CALC_ADDRESS = 3'd2,
        ADDRESS_READ = 3'd3,
        DATA_READ    = 3'd4,
        DONE         = 3'd5,
        ERROR        = 3'd7
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  chan_q, chan_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] len_q, len_d;
    logic [31:0] offset_q, offset_d;
    logic [31:0] araddr_q, araddr_d;
    logic [7:0]  arlen_q, arlen_d;
    logic        arvalid_q, arvalid_d;
    logic [7:0]  beat_q, beat_d;
    logic [2:0]  err_q, err_d;

    logic [1:0]  sel;
    logic        sel_ok;
    logic [31:0] remaining;
    logic [4:0]  room_base;
    logic [5:0]  room;
    logic [7:0]  burst_len;
    logic [31:0] offset_next;
    logic        beat_fire;
    logic        unused_rid;

`ifdef PAINTERENGINE_GPU_READER_TIMEOUT_EN
    logic [15:0] wd_q, wd_d;
`endif

    always_comb begin
        sel    = 2'd0;
        sel_ok = 1'b1;
        case (i_wire_router)
            4'b0001: sel = 2'd0;
            4'b0010: sel = 2'd1;
            4'b0100: sel = 2'd2;
            4'b1000: sel = 2'd3;
            default: sel_ok = 1'b0;
        endcase
    end

    // Room to the next 128-byte line; a zero word index within the line means a full 32-beat burst fits.
    assign remaining   = len_q - offset_q;
    assign room_base   = addr_q[6:2] + offset_q[4:0];
    assign room        = 6'd32 - {1'b0, room_base};
    assign burst_len   = (remaining < {26'd0, room}) ? remaining[7:0] : {2'b00, room};
    assign offset_next = offset_q + {24'd0, arlen_q} + 32'd1;
    assign beat_fire   = m_axi.rvalid & m_axi.rready;

    always_comb begin
        state_d   = state_q;
        chan_d    = chan_q;
        addr_d    = addr_q;
        len_d     = len_q;
        offset_d  = offset_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arvalid_d = arvalid_q;
        beat_d    = beat_q;
        err_d     = err_q;
        case (state_q)
            ROUTING: begin
                if (sel_ok) begin
                    chan_d  = sel;
                    addr_d  = i_wire_address[{sel, 5'd0} +: 32];
                    len_d   = i_wire_length[{sel, 5'd0} +: 32];
                    state_d = PARAM_CHECK;
                end else begin
                    err_d   = 3'b001;
                    state_d = ERROR;
                end
            end
            PARAM_CHECK: begin
                if (addr_q[1:0] != 2'b00 || len_q == 32'd0) begin
                    err_d   = 3'b010;
                    state_d = ERROR;
                end else begin
                    offset_d = 32'd0;
                    state_d  = CALC_ADDRESS;
                end
            end
            CALC_ADDRESS: begin
                araddr_d  = addr_q + {offset_q[29:0], 2'b00};
                arlen_d   = burst_len - 8'd1;
                arvalid_d = 1'b1;
                state_d   = ADDRESS_READ;
            end
            ADDRESS_READ: begin
                if (m_axi.arready) begin
                    arvalid_d = 1'b0;
                    beat_d    = 8'd0;
                    state_d   = DATA_READ;
                end
            end
            DATA_READ: begin
                if (beat_fire) begin
                    if (m_axi.rresp[1]) begin
                        err_d   = 3'b011;
                        state_d = ERROR;
                    end else if (beat_q == arlen_q) begin
                        if (!m_axi.rlast) begin
                            err_d   = 3'b101;
                            state_d = ERROR;
                        end else begin
                            offset_d = offset_next;
                            state_d  = (offset_next >= len_q) ? DONE : CALC_ADDRESS;
                        end
                    end else if (m_axi.rlast) begin
                        err_d   = 3'b101;
                        state_d = ERROR;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            DONE:    state_d = DONE;
            ERROR:   state_d = ERROR;
            default: begin
                err_d   = 3'b101;
                state_d = ERROR;
            end
        endcase
`ifdef PAINTERENGINE_GPU_READER_TIMEOUT_EN
        wd_d = 16'd0;
        if ((state_q == ADDRESS_READ && !m_axi.arready) || (state_q == DATA_READ && !beat_fire))
            wd_d = wd_q + 16'd1;
        if (wd_q == 16'hFFFF) begin
            err_d     = 3'b100;
            arvalid_d = 1'b0;
            state_d   = ERROR;
        end
`endif
    end

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            state_q   <= ROUTING;
            chan_q    <= 2'd0;
            addr_q    <= 32'd0;
            len_q     <= 32'd0;
            offset_q  <= 32'd0;
            araddr_q  <= 32'd0;
            arlen_q   <= 8'd0;
            arvalid_q <= 1'b0;
            beat_q    <= 8'd0;
            err_q     <= 3'b000;
        end else begin
            state_q   <= state_d;
            chan_q    <= chan_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            offset_q  <= offset_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arvalid_q <= arvalid_d;
            beat_q    <= beat_d;
            err_q     <= err_d;
        end
    end

`ifdef PAINTERENGINE_GPU_READER_TIMEOUT_EN
    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) wd_q <= 16'd0;
        else                wd_q <= wd_d;
    end
`endif

    assign o_wire_data       = (state_q == DATA_READ) ? m_axi.rdata : '0;
    assign o_wire_data_valid = (state_q == DATA_READ && m_axi.rvalid) ? (4'b0001 << chan_q) : 4'b0000;
    assign o_wire_done       = (state_q == DONE);
    assign o_wire_error      = (state_q == ERROR);
    assign o_wire_error_type = err_q;

    assign m_axi.arid    = 1'b0;
    assign m_axi.araddr  = araddr_q;
    assign m_axi.arlen   = arlen_q;
    assign m_axi.arsize  = 3'b010;
    assign m_axi.arburst = 2'b01;
    assign m_axi.arlock  = 1'b0;
    assign m_axi.arcache = 4'b0010;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arqos   = 4'b0000;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = (state_q == DATA_READ) && i_wire_data_next[chan_q];
    assign unused_rid    = m_axi.rid;

endmodule

// File: tb/tb_painterengine_gpu_dma_reader.sv
// Scoreboard bench: tests push expected AR requests and data words; a negedge monitor pops on every handshake.
module tb_painterengine_gpu_dma_reader;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   router;
    logic [127:0] address, length;
    logic [31:0]  data;
    logic [3:0]   dvalid, dnext;
    logic         done, error;
    logic [2:0]   etype;

    always #5 clk = ~clk;

    painterengine_gpu_dma_reader_if axi ();

    painterengine_gpu_dma_reader dut (
        .i_wire_clock      (clk),
        .i_wire_resetn     (rst_n),
        .i_wire_router     (router),
        .i_wire_address    (address),
        .i_wire_length     (length),
        .o_wire_data       (data),
        .o_wire_data_valid (dvalid),
        .i_wire_data_next  (dnext),
        .o_wire_done       (done),
        .o_wire_error      (error),
        .o_wire_error_type (etype),
        .m_axi             (axi)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    ar_t         exp_ar[$];
    logic [31:0] exp_dat[$];
    int checks = 0, failures = 0;
    int exp_ch = 0, beats_seen = 0, stall_cycles = 0, ar_seen = 0;
    logic slave_en = 1'b0;
    int resp_err_beat = -1, early_last_beat = -1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: AR handshakes and consumed data beats against the queues.
    initial begin
        ar_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (axi.arvalid && axi.arready) begin
                    ar_seen++;
                    checks++;
                    if (exp_ar.size() == 0) begin
                        failures++;
                        $display("FAIL ar_unexpected actual=%0h required=none", axi.araddr);
                    end else begin
                        e = exp_ar.pop_front();
                        checks--;
                        check("araddr", axi.araddr, e.addr);
                        check("arlen", axi.arlen, e.len);
                    end
                end
                if (axi.rvalid) begin
                    check("dvalid", dvalid, 4'b0001 << exp_ch);
                    check("rready", axi.rready, dnext[exp_ch]);
                    if (!axi.rready) stall_cycles++;
                    else begin
                        beats_seen++;
                        checks++;
                        if (exp_dat.size() == 0) begin
                            failures++;
                            $display("FAIL data_unexpected actual=%0h required=none", data);
                        end else begin
                            checks--;
                            check("rdata", data, exp_dat.pop_front());
                        end
                    end
                end
            end
        end
    end

    // Memory slave: one burst at a time, optional injected response/last faults.
    initial begin
        logic [31:0] a;
        logic [7:0]  n;
        logic        stop;
        int          wcnt;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0;
        axi.rresp = 2'b00; axi.rlast = 1'b0; axi.rid = 1'b0;
        forever begin
            @(negedge clk);
            if (slave_en && axi.arvalid && axi.arready) begin
                a = axi.araddr;
                n = axi.arlen;
                @(posedge clk); #1;
                for (int i = 0; i <= int'(n); i++) begin
                    axi.rvalid = 1'b1;
                    axi.rdata  = mem_word(a + 32'(4 * i));
                    axi.rresp  = (i == resp_err_beat) ? 2'b10 : 2'b00;
                    axi.rlast  = (i == int'(n)) || (i == early_last_beat);
                    stop       = axi.rlast || axi.rresp[1];
                    wcnt = 0;
                    do begin
                        @(negedge clk);
                        wcnt++;
                    end while (!axi.rready && slave_en && wcnt < 1000);
                    @(posedge clk); #1;
                    if (stop || !slave_en) break;
                end
                axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        slave_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        exp_ar.delete();
        exp_dat.delete();
        beats_seen = 0; stall_cycles = 0; ar_seen = 0;
        resp_err_beat = -1; early_last_beat = -1;
        dnext = 4'hF;
        axi.arready = 1'b1;
        router = 4'd0; address = '0; length = '0;
    endtask

    task automatic release_reset();
        slave_en = 1'b1;
        rst_n = 1'b1;
    endtask

    task automatic wait_end(input string name, input int budget);
        int n = 0;
        while (!(done || error) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(done || error)) begin
            failures++;
            $display("FAIL %s_timeout actual=running required=finished", name);
        end
    endtask

    task automatic push_words(input logic [31:0] a, input int cnt);
        for (int i = 0; i < cnt; i++) exp_dat.push_back(mem_word(a + 32'(4 * i)));
    endtask

    initial begin
        router = 4'd0; address = '0; length = '0; dnext = 4'hF;

        // Reset values
        do_reset();
        @(negedge clk);
        check("rst_data", data, 0);
        check("rst_dvalid", dvalid, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_etype", etype, 0);
        check("rst_arvalid", axi.arvalid, 0);
        check("rst_rready", axi.rready, 0);
        check("rst_arsize", axi.arsize, 3'b010);
        check("rst_arburst", axi.arburst, 2'b01);
        check("rst_arcache", axi.arcache, 4'b0010);

        // Single aligned burst on channel 1 with latency check
        router = 4'b0010; address[63:32] = 32'h1000; length[63:32] = 32'd8; exp_ch = 1;
        exp_ar.push_back('{32'h1000, 8'd7});
        push_words(32'h1000, 8);
        release_reset();
        @(negedge clk); check("lat_c1", axi.arvalid, 0);
        @(negedge clk); check("lat_c2", axi.arvalid, 0);
        @(negedge clk); check("lat_c3", axi.arvalid, 1);
        wait_end("t1", 200);
        check("t1_done", done, 1);
        check("t1_etype", etype, 0);
        check("t1_beats", beats_seen, 8);
        check("t1_left", exp_dat.size() + exp_ar.size(), 0);

        // 128-byte boundary splitting
        do_reset();
        router = 4'b0001; address[31:0] = 32'h1070; length[31:0] = 32'd40; exp_ch = 0;
        exp_ar.push_back('{32'h1070, 8'd3});
        exp_ar.push_back('{32'h1080, 8'd31});
        exp_ar.push_back('{32'h1100, 8'd3});
        push_words(32'h1070, 40);
        release_reset();
        wait_end("t2", 500);
        check("t2_done", done, 1);
        check("t2_beats", beats_seen, 40);
        check("t2_left", exp_dat.size() + exp_ar.size(), 0);

        // Consumer backpressure on channel 2
        do_reset();
        router = 4'b0100; address[95:64] = 32'h3000; length[95:64] = 32'd4; exp_ch = 2;
        exp_ar.push_back('{32'h3000, 8'd3});
        push_words(32'h3000, 4);
        release_reset();
        for (int g = 0; g < 100 && beats_seen < 2; g++) @(posedge clk);
        #1; dnext = 4'h0;
        repeat (3) @(posedge clk);
        #1; dnext = 4'hF;
        wait_end("t3", 200);
        check("t3_done", done, 1);
        check("t3_stall", stall_cycles, 3);
        check("t3_left", exp_dat.size() + exp_ar.size(), 0);

        // Invalid router
        do_reset();
        router = 4'b0011; length[31:0] = 32'd4;
        release_reset();
        wait_end("t4", 20);
        check("t4_error", error, 1);
        check("t4_etype", etype, 3'b001);
        check("t4_ar", ar_seen, 0);

        // Misaligned address
        do_reset();
        router = 4'b1000; address[127:96] = 32'h1002; length[127:96] = 32'd4; exp_ch = 3;
        release_reset();
        wait_end("t5", 20);
        check("t5_error", error, 1);
        check("t5_etype", etype, 3'b010);
        check("t5_ar", ar_seen, 0);

        // Error response on beat 2
        do_reset();
        router = 4'b0001; address[31:0] = 32'h2000; length[31:0] = 32'd8; exp_ch = 0;
        resp_err_beat = 2;
        exp_ar.push_back('{32'h2000, 8'd7});
        push_words(32'h2000, 3);
        release_reset();
        wait_end("t6", 200);
        check("t6_etype", etype, 3'b011);
        check("t6_done", done, 0);
        check("t6_left", exp_dat.size(), 0);

        // Early RLAST
        do_reset();
        router = 4'b0001; address[31:0] = 32'h2000; length[31:0] = 32'd4; exp_ch = 0;
        early_last_beat = 0;
        exp_ar.push_back('{32'h2000, 8'd3});
        push_words(32'h2000, 1);
        release_reset();
        wait_end("t7", 200);
        check("t7_etype", etype, 3'b101);
        check("t7_left", exp_dat.size(), 0);

        // Address channel stall
        do_reset();
        router = 4'b0001; address[31:0] = 32'h4000; length[31:0] = 32'd4; exp_ch = 0;
        axi.arready = 1'b0;
        release_reset();
`ifdef PAINTERENGINE_GPU_READER_TIMEOUT_EN
        wait_end("t8", 66000);
        check("t8_error", error, 1);
        check("t8_etype", etype, 3'b100);
`else
        repeat (70000) @(negedge clk);
        check("t8_arvalid", axi.arvalid, 1);
        check("t8_araddr", axi.araddr, 32'h4000);
        check("t8_error", error, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
